// File: rtl/lioncage_pkg.sv
// Shared types for the lion cage gate controller: transit FSM states and counter width.
package lioncage_pkg;

    localparam int COUNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        IN1,
        IN2,
        IN3,
        OUT1,
        OUT2,
        OUT3,
        FAULT
    } gate_state_t;

endpackage

// File: rtl/lioncage_gate_ctrl_if.sv
// Gate sensor inputs, clear request and occupancy/event outputs of the cage controller.
interface lioncage_gate_ctrl_if;
    import lioncage_pkg::*;

    logic               gate_a_i;
    logic               gate_b_i;
    logic               clear_i;
    logic [COUNT_W-1:0] count_o;
    logic               full_o;
    logic               empty_o;
    logic               lock_o;
    logic               alarm_o;
    logic               evt_in_o;
    logic               evt_out_o;

    modport master (
        output gate_a_i, gate_b_i, clear_i,
        input  count_o, full_o, empty_o, lock_o, alarm_o, evt_in_o, evt_out_o
    );

    modport slave (
        input  gate_a_i, gate_b_i, clear_i,
        output count_o, full_o, empty_o, lock_o, alarm_o, evt_in_o, evt_out_o
    );

endinterface

// File: rtl/lioncage_gate_ctrl_debounce.sv
// One light gate: two-flop synchronizer followed by a stability counter that accepts
// a new level only after it has been seen for DEBOUNCE_CYCLES consecutive cycles.
module gate_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    logic       sync_p0;
    logic       sync_p1;
    logic [7:0] stable_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Any return to the accepted level restarts the count, so short glitches never land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_cnt <= 8'd0;
            level      <= 1'b0;
        end else if (sync_p1 == level) begin
            stable_cnt <= 8'd0;
        end else if (stable_cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
            stable_cnt <= 8'd0;
            level      <= sync_p1;
        end else begin
            stable_cnt <= stable_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/lioncage_gate_ctrl.sv
// Lion cage occupancy counter: tracks transits through a two-beam gate, counts
// committed entries/exits and raises a sticky alarm on illegal sequences or over/underflow.
module lioncage_gate_ctrl
    import lioncage_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_LIONS       = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    lioncage_gate_ctrl_if.slave  bus
);

    logic               gate_a;
    logic               gate_b;
    logic [1:0]         pat;
    gate_state_t        state;
    gate_state_t        state_next;
    logic               commit_in;
    logic               commit_out;
    logic [COUNT_W-1:0] count;
    logic               alarm;
    logic               evt_in;
    logic               evt_out;
    logic               at_max;
    logic               at_zero;

    gate_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.gate_a_i),
        .level (gate_a)
    );

    gate_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.gate_b_i),
        .level (gate_b)
    );

    assign pat = {gate_a, gate_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (bus.clear_i) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_next;
        end
    end

    // Each state owns one pattern; holding it stays put, neighbours step, anything else faults.
    always_comb begin
        state_next = state;
        commit_in  = 1'b0;
        commit_out = 1'b0;
        case (state)
            IDLE: begin
                case (pat)
                    2'b00:   state_next = IDLE;
                    2'b10:   state_next = IN1;
                    2'b01:   state_next = OUT1;
                    default: state_next = FAULT;
                endcase
            end
            IN1: begin
                case (pat)
                    2'b10:   state_next = IN1;
                    2'b11:   state_next = IN2;
                    2'b00:   state_next = IDLE;
                    default: state_next = FAULT;
                endcase
            end
            IN2: begin
                case (pat)
                    2'b11:   state_next = IN2;
                    2'b01:   state_next = IN3;
                    2'b10:   state_next = IN1;
                    default: state_next = FAULT;
                endcase
            end
            IN3: begin
                case (pat)
                    2'b01:   state_next = IN3;
                    2'b11:   state_next = IN2;
                    2'b00: begin
                        state_next = IDLE;
                        commit_in  = 1'b1;
                    end
                    default: state_next = FAULT;
                endcase
            end
            OUT1: begin
                case (pat)
                    2'b01:   state_next = OUT1;
                    2'b11:   state_next = OUT2;
                    2'b00:   state_next = IDLE;
                    default: state_next = FAULT;
                endcase
            end
            OUT2: begin
                case (pat)
                    2'b11:   state_next = OUT2;
                    2'b10:   state_next = OUT3;
                    2'b01:   state_next = OUT1;
                    default: state_next = FAULT;
                endcase
            end
            OUT3: begin
                case (pat)
                    2'b10:   state_next = OUT3;
                    2'b11:   state_next = OUT2;
                    2'b00: begin
                        state_next = IDLE;
                        commit_out = 1'b1;
                    end
                    default: state_next = FAULT;
                endcase
            end
            default: begin
                state_next = (pat == 2'b00) ? IDLE : FAULT;
            end
        endcase
    end

    assign at_max  = (count == COUNT_W'(MAX_LIONS));
    assign at_zero = (count == '0);

    // Clear wins over a same-cycle commit; a saturated commit only raises the alarm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            alarm   <= 1'b0;
            evt_in  <= 1'b0;
            evt_out <= 1'b0;
        end else if (bus.clear_i) begin
            count   <= '0;
            alarm   <= 1'b0;
            evt_in  <= 1'b0;
            evt_out <= 1'b0;
        end else begin
            evt_in  <= 1'b0;
            evt_out <= 1'b0;
            if (ena) begin
                if (state_next == FAULT) begin
                    alarm <= 1'b1;
                end
                if (commit_in) begin
                    if (at_max) begin
                        alarm <= 1'b1;
                    end else begin
                        count  <= count + COUNT_W'(1);
                        evt_in <= 1'b1;
                    end
                end
                if (commit_out) begin
                    if (at_zero) begin
                        alarm <= 1'b1;
                    end else begin
                        count   <= count - COUNT_W'(1);
                        evt_out <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.count_o   = count;
    assign bus.full_o    = at_max;
    assign bus.empty_o   = at_zero;
    assign bus.lock_o    = at_max;
    assign bus.alarm_o   = alarm;
    assign bus.evt_in_o  = evt_in;
    assign bus.evt_out_o = evt_out;

endmodule

// File: tb/tb_lioncage_gate_ctrl.sv
// Bench for lioncage_gate_ctrl: directed transits plus a biased random walk, checked
// against a track-position model of the gate (position along entry/exit path).
module tb_lioncage_gate_ctrl;

    localparam int DEB  = 4;
    localparam int MAXL = 15;
    localparam int HOLD = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ena   = 1'b1;

    lioncage_gate_ctrl_if bus ();

    lioncage_gate_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .MAX_LIONS       (MAXL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Running totals of observed event pulses.
    int tot_in  = 0;
    int tot_out = 0;
    always @(negedge clk) begin
        if (bus.evt_in_o === 1'b1)  tot_in++;
        if (bus.evt_out_o === 1'b1) tot_out++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Model: position along the track (+1..+3 entry, -1..-3 exit, 0 idle), fault flag.
    int         m_pos   = 0;
    int         m_count = 0;
    bit         m_fault = 1'b0;
    bit         m_alarm = 1'b0;
    int         m_in    = 0;
    int         m_out   = 0;
    bit         m_ena   = 1'b1;
    int         b_in    = 0;
    int         b_out   = 0;
    logic [1:0] cur     = 2'b00;

    function automatic logic [1:0] track(input int pos);
        case (pos)
            1, -3:   return 2'b10;
            2, -2:   return 2'b11;
            3, -1:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic void model_apply(input logic [1:0] p);
        int dir;
        if (m_fault) begin
            if (p == 2'b00) m_fault = 1'b0;
            return;
        end
        if (p == track(m_pos)) return;
        if (m_pos == 0) begin
            if (p == 2'b10)      m_pos = 1;
            else if (p == 2'b01) m_pos = -1;
            else begin
                m_fault = 1'b1;
                m_alarm = 1'b1;
            end
            return;
        end
        dir = (m_pos > 0) ? 1 : -1;
        if (p == track(m_pos + dir))      m_pos = m_pos + dir;
        else if (p == track(m_pos - dir)) m_pos = m_pos - dir;
        else begin
            m_pos   = 0;
            m_fault = 1'b1;
            m_alarm = 1'b1;
        end
        if (m_pos == 4) begin
            m_pos = 0;
            if (m_count == MAXL) m_alarm = 1'b1;
            else begin
                m_count++;
                m_in++;
            end
        end else if (m_pos == -4) begin
            m_pos = 0;
            if (m_count == 0) m_alarm = 1'b1;
            else begin
                m_count--;
                m_out++;
            end
        end
    endfunction

    function automatic void model_clear();
        m_count = 0;
        m_alarm = 1'b0;
        m_pos   = 0;
        m_fault = 1'b0;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic begin_window();
        m_in  = 0;
        m_out = 0;
        b_in  = tot_in;
        b_out = tot_out;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ":count"}, int'(bus.count_o), m_count);
        chk({tag, ":full"},  int'(bus.full_o),  int'(m_count == MAXL));
        chk({tag, ":empty"}, int'(bus.empty_o), int'(m_count == 0));
        chk({tag, ":lock"},  int'(bus.lock_o),  int'(m_count == MAXL));
        chk({tag, ":alarm"}, int'(bus.alarm_o), int'(m_alarm));
        chk({tag, ":n_in"},  tot_in - b_in,     m_in);
        chk({tag, ":n_out"}, tot_out - b_out,   m_out);
    endtask

    task automatic drive(input logic [1:0] p);
        cur          = p;
        bus.gate_a_i = p[1];
        bus.gate_b_i = p[0];
    endtask

    // Drive a pattern, hold it long enough to settle, then compare against the model.
    task automatic step(input logic [1:0] p, input string tag);
        begin_window();
        drive(p);
        if (m_ena) model_apply(p);
        repeat (HOLD) @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic entry(input string tag);
        step(2'b10, tag);
        step(2'b11, tag);
        step(2'b01, tag);
        step(2'b00, tag);
    endtask

    task automatic exit_walk(input string tag);
        step(2'b01, tag);
        step(2'b11, tag);
        step(2'b10, tag);
        step(2'b00, tag);
    endtask

    task automatic do_clear(input string tag);
        begin_window();
        bus.clear_i = 1'b1;
        @(posedge clk);
        #1;
        bus.clear_i = 1'b0;
        model_clear();
        model_apply(cur);
        repeat (HOLD) @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    // Flip one gate for fewer cycles than the debounce window; the model sees nothing.
    task automatic glitch(input int bit_sel, input int len, input string tag);
        logic [1:0] g;
        begin_window();
        g = cur;
        g[bit_sel] = ~g[bit_sel];
        bus.gate_a_i = g[1];
        bus.gate_b_i = g[0];
        repeat (len) @(posedge clk);
        #1;
        drive(cur);
        repeat (HOLD) @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        int lat;
        logic [1:0] p;
        bus.gate_a_i = 1'b0;
        bus.gate_b_i = 1'b0;
        bus.clear_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        begin_window();
        check_outputs("reset");
        chk("reset:evt_in",  int'(bus.evt_in_o),  0);
        chk("reset:evt_out", int'(bus.evt_out_o), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Clean entry, with the commit pulse timed from the final raw change.
        step(2'b10, "entry1");
        step(2'b11, "entry1");
        step(2'b01, "entry1");
        begin_window();
        drive(2'b00);
        model_apply(2'b00);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk);
            #1;
            if (bus.evt_in_o === 1'b1) lat = i;
        end
        chk("entry1:evt_latency", lat, DEB + 3);
        repeat (5) @(posedge clk);
        #1;
        check_outputs("entry1_done");

        entry("entry2");
        entry("entry3");
        exit_walk("exit_from3");

        // Aborted entry and retreat steps.
        step(2'b10, "abort");
        step(2'b11, "abort");
        step(2'b10, "abort");
        step(2'b00, "abort");
        step(2'b10, "retreat");
        step(2'b11, "retreat");
        step(2'b01, "retreat");
        step(2'b11, "retreat");
        step(2'b01, "retreat");
        step(2'b00, "retreat");

        glitch(1, 2, "glitch_idle");
        step(2'b01, "glitch_exit");
        step(2'b11, "glitch_exit");
        step(2'b10, "glitch_exit");
        glitch(1, DEB - 1, "glitch_out3");
        step(2'b00, "glitch_exit");

        // Fill to capacity, then overflow and underflow.
        do_clear("clear_fill");
        for (int k = 0; k < MAXL; k++) entry("fill");
        entry("overflow");
        do_clear("clear_under");
        exit_walk("underflow");
        do_clear("clear_fault");

        // Illegal two-bit jump, recovery, then clear on the commit cycle.
        step(2'b11, "fault");
        step(2'b00, "fault_idle");
        entry("after_fault");
        do_clear("clear_alarm");
        entry("pre_clr");
        step(2'b10, "clr_commit");
        step(2'b11, "clr_commit");
        step(2'b01, "clr_commit");
        begin_window();
        drive(2'b00);
        repeat (DEB + 2) @(posedge clk);
        #1;
        bus.clear_i = 1'b1;
        @(posedge clk);
        #1;
        bus.clear_i = 1'b0;
        model_clear();
        repeat (HOLD) @(posedge clk);
        #1;
        check_outputs("clr_commit");

        // Enable low freezes the FSM and counter; clear still works.
        entry("pre_ena");
        ena   = 1'b0;
        m_ena = 1'b0;
        entry("ena_low");
        exit_walk("ena_low");
        do_clear("ena_low_clear");
        ena   = 1'b1;
        m_ena = 1'b1;
        entry("ena_back");

        // Asynchronous reset in the middle of an entry.
        step(2'b10, "pre_rst");
        step(2'b11, "pre_rst");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        begin_window();
        model_clear();
        check_outputs("async_rst");
        chk("async_rst:evt_in",  int'(bus.evt_in_o),  0);
        chk("async_rst:evt_out", int'(bus.evt_out_o), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        begin_window();
        model_apply(cur);
        repeat (HOLD) @(posedge clk);
        #1;
        check_outputs("rst_release");
        step(2'b01, "rst_after");
        step(2'b00, "rst_after");
        do_clear("clear_rand");

        // Biased random walk with occasional glitches and clears.
        for (int s = 0; s < 80; s++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                do_clear("rand_clear");
            end else if (r < 3) begin
                glitch(int'($urandom_range(0, 1)), int'($urandom_range(1, DEB - 1)), "rand_glitch");
            end else begin
                if (r < 14 && !m_fault) begin
                    if (m_pos == 0)     p = ($urandom_range(0, 2) != 0) ? 2'b10 : 2'b01;
                    else if (m_pos > 0) p = track(m_pos + 1);
                    else                p = track(m_pos - 1);
                end else begin
                    p = 2'($urandom_range(0, 3));
                end
                step(p, "rand_step");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lioncage_gate_ctrl.md
LIONCAGE_GATE_CTRL -- requirements
Module: lioncage_gate_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable cycles before a gate level is accepted (range 1..255).
REQ-002 SHALL have parameter MAX_LIONS, default 15, meaning cage capacity (range 1..15).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset: asynchronous, active-low.
REQ-005 SHALL have port ena, input, 1, meaning enable; low freezes the FSM and the counter.
REQ-006 SHALL have port gate_a_i, input, 1, meaning raw outer light gate (1 = beam broken), asynchronous to clk.
REQ-007 SHALL have port gate_b_i, input, 1, meaning raw inner light gate (1 = beam broken), asynchronous to clk.
REQ-008 SHALL have port clear_i, input, 1, meaning synchronous clear of count and alarm.
REQ-009 SHALL have port count_o, output, 4, meaning current occupancy, feeds seg7.
REQ-010 SHALL have port full_o / empty_o, output, 1 each, meaning count_o==MAX_LIONS / count_o==0.
REQ-011 SHALL have port lock_o, output, 1, meaning outer door lock request, equal to full_o.
REQ-012 SHALL have port alarm_o, output, 1, meaning sticky fault flag.
REQ-013 SHALL have port evt_in_o / evt_out_o, output, 1 each, meaning one-cycle pulse on committed entry / exit.

Function
REQ-014 SHALL pass each gate through a 2-flop synchronizer, then a debouncer; debounced level changes DEBOUNCE_CYCLES+2 cycles after a stable raw change; glitches shorter than DEBOUNCE_CYCLES SHALL be rejected.
REQ-015 SHALL run FSM on debounced pair {a,b} with states IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, FAULT.
REQ-016 Entry path: IDLE-10->IN1-11->IN2-01->IN3-00->IDLE with commit entry.
REQ-017 Exit path: IDLE-01->OUT1-11->OUT2-10->OUT3-00->IDLE with commit exit.
REQ-018 Retreat SHALL be legal one step back (IN2-10->IN1, IN3-11->IN2, OUT2-01->OUT1, OUT3-11->OUT2); IN1-00 or OUT1-00 SHALL return to IDLE with no commit.
REQ-019 Any other pattern change (e.g. IDLE-11, IN1-01, two-bit jump) SHALL enter FAULT and set alarm_o; FAULT exits to IDLE only on 00.
REQ-020 Commit entry SHALL increment count_o and pulse evt_in_o in the cycle after the 00 is seen; commit exit likewise decrements count_o and pulses evt_out_o.
REQ-021 Entry commit at count==MAX_LIONS SHALL hold count, suppress evt_in_o, set alarm_o; exit commit at count==0 SHALL hold count, suppress evt_out_o, set alarm_o (no wrap-around).
REQ-022 clear_i SHALL zero count_o and alarm_o next cycle, force FSM to IDLE, and take priority over a simultaneous commit (no event pulse).
REQ-023 ena low SHALL hold FSM state, count and alarm; debouncers keep running; clear_i still acts.
REQ-024 All outputs SHALL be registered or decoded only from registered count.

Reset
REQ-025 rst_n low SHALL asynchronously set count_o=0, empty_o=1, full_o=0, lock_o=0, alarm_o=0, evt pulses=0, FSM=IDLE, synchronizers and debounced levels=0.
REQ-026 Reset mid-sequence SHALL discard the partial transit; no commit after release.

Structure
REQ-027 Package lioncage_pkg SHALL hold the FSM state enum and the 4-bit count width constant.
REQ-028 Debounce SHALL be sub-module gate_debounce (synchronizer + stability counter), instantiated once per gate.

Verification (DEBOUNCE_CYCLES=4, MAX_LIONS=15)
REQ-029 Clean entry 00,10,11,01,00 each held 10 cycles -> count 0->1, single evt_in_o pulse, alarm 0.
REQ-030 Clean exit from count=3 (01,11,10,00) -> count 2, single evt_out_o pulse.
REQ-031 Entry aborted 10,11,10,00 -> count unchanged, no pulses; 2-cycle glitch on gate_a_i -> no state change.
REQ-032 15 entries then a 16th -> count 15, full_o=lock_o=1, 16th gives alarm_o=1, no evt_in_o; exit at 0 likewise alarms.
REQ-033 Direct 00->11 -> FAULT, alarm_o=1; return to 00 -> IDLE, alarm stays until clear_i; clear_i on commit cycle -> count 0, no pulse.
REQ-034 rst_n asserted asynchronously during IN2 -> all outputs at reset values immediately; after release, completing 01,00 gives no commit.
